// File: rtl/mips_cache_pkg.sv
// Shared types for the MIPS cache port arbiter: transaction FSM states and requester ids.
`timescale 1ns/1ps
package mips_cache_pkg;
  typedef enum logic [2:0] {IDLE, LOOK, CHK, MEM, FILL, RESP} state_t;
  localparam logic P_IF  = 1'b0;
  localparam logic P_MEM = 1'b1;
endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin arbiter; last_gnt resets to 1 so requester 0 wins the first tie.
`timescale 1ns/1ps
module rr_arbiter2 (
  input  logic       clk,
  input  logic       rst,
  input  logic [1:0] req,
  input  logic       take,
  output logic       gnt,
  output logic       any
);
  logic last_gnt;

  always_comb begin
    any = |req;
    gnt = (req == 2'b11) ? ~last_gnt : req[1];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)              last_gnt <= 1'b1;
    else if (take && any) last_gnt <= gnt;
  end
endmodule

// File: rtl/cache_port_arbiter.sv
// Shares a single-port write-through cache between IF (port 0) and MEM (port 1).
// Optional mem_ack watchdog: define CACHE_ARB_TIMEOUT_EN.
`timescale 1ns/1ps
module cache_port_arbiter import mips_cache_pkg::*; #(
  parameter int AW             = 32,
  parameter int DW             = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          p0_req,
  input  logic          p0_wr,
  input  logic [AW-1:0] p0_addr,
  input  logic [DW-1:0] p0_wdata,
  output logic          p0_done,
  output logic [DW-1:0] p0_rdata,
  output logic          p0_err,
  input  logic          p1_req,
  input  logic          p1_wr,
  input  logic [AW-1:0] p1_addr,
  input  logic [DW-1:0] p1_wdata,
  output logic          p1_done,
  output logic [DW-1:0] p1_rdata,
  output logic          p1_err,
  output logic          c_en,
  output logic          c_wr,
  output logic [AW-1:0] c_addr,
  output logic [DW-1:0] c_wdata,
  input  logic          c_hit,
  input  logic [DW-1:0] c_rdata,
  output logic          fill_en,
  output logic [AW-1:0] fill_addr,
  output logic [DW-1:0] fill_data,
  output logic          mem_req,
  output logic          mem_we,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic          mem_ack,
  input  logic [DW-1:0] mem_rdata,
  output state_t        state
);
  logic          gnt, any;
  logic          txn_port, txn_wr;
  logic [AW-1:0] txn_addr;
  logic [DW-1:0] txn_wdata, rdata_q;

  rr_arbiter2 u_arb (
    .clk  (clk),
    .rst  (rst),
    .req  ({p1_req, p0_req}),
    .take (state == IDLE),
    .gnt  (gnt),
    .any  (any)
  );

  // Address/data buses come straight from the captured transaction; strobes qualify them.
  assign c_addr    = txn_addr;
  assign c_wdata   = txn_wdata;
  assign mem_addr  = txn_addr;
  assign mem_wdata = txn_wdata;
  assign fill_addr = txn_addr;
  assign fill_data = rdata_q;
  assign p0_rdata  = rdata_q;
  assign p1_rdata  = rdata_q;

`ifdef CACHE_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT_CYCLES + 1);
  logic [CW-1:0] cnt;
  logic          err_q;
  assign p0_err = err_q;
  assign p1_err = err_q;
`else
  assign p0_err = 1'b0;
  assign p1_err = 1'b0;
`endif

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state     <= IDLE;
      txn_port  <= P_IF;
      txn_wr    <= 1'b0;
      txn_addr  <= '0;
      txn_wdata <= '0;
      rdata_q   <= '0;
      c_en      <= 1'b0;
      c_wr      <= 1'b0;
      fill_en   <= 1'b0;
      mem_req   <= 1'b0;
      mem_we    <= 1'b0;
      p0_done   <= 1'b0;
      p1_done   <= 1'b0;
`ifdef CACHE_ARB_TIMEOUT_EN
      cnt       <= '0;
      err_q     <= 1'b0;
`endif
    end else begin
      c_en    <= 1'b0;
      c_wr    <= 1'b0;
      fill_en <= 1'b0;
      p0_done <= 1'b0;
      p1_done <= 1'b0;
      case (state)
        IDLE: if (any) begin
          txn_port  <= gnt;
          txn_wr    <= gnt ? p1_wr    : p0_wr;
          txn_addr  <= gnt ? p1_addr  : p0_addr;
          txn_wdata <= gnt ? p1_wdata : p0_wdata;
          c_en      <= 1'b1;
          c_wr      <= gnt ? p1_wr : p0_wr;
`ifdef CACHE_ARB_TIMEOUT_EN
          err_q     <= 1'b0;
`endif
          state     <= LOOK;
        end
        LOOK: state <= CHK;
        CHK: begin
          if (!txn_wr && c_hit) begin
            rdata_q            <= c_rdata;
            {p1_done, p0_done} <= txn_port ? 2'b10 : 2'b01;
            state              <= RESP;
          end else begin
            mem_req <= 1'b1;
            mem_we  <= txn_wr;
`ifdef CACHE_ARB_TIMEOUT_EN
            cnt     <= '0;
`endif
            state   <= MEM;
          end
        end
        MEM: begin
          if (mem_ack) begin
            mem_req <= 1'b0;
            mem_we  <= 1'b0;
            if (txn_wr) begin
              {p1_done, p0_done} <= txn_port ? 2'b10 : 2'b01;
              state              <= RESP;
            end else begin
              rdata_q <= mem_rdata;
              fill_en <= 1'b1;
              state   <= FILL;
            end
          end
`ifdef CACHE_ARB_TIMEOUT_EN
          else if (cnt == CW'(TIMEOUT_CYCLES - 1)) begin
            // Abandon the memory request: report an error with zero data and skip the fill.
            mem_req            <= 1'b0;
            mem_we             <= 1'b0;
            err_q              <= 1'b1;
            rdata_q            <= '0;
            {p1_done, p0_done} <= txn_port ? 2'b10 : 2'b01;
            state              <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
          end
`endif
        end
        FILL: begin
          {p1_done, p0_done} <= txn_port ? 2'b10 : 2'b01;
          state              <= RESP;
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_cache_port_arbiter.sv
// Directed bench for cache_port_arbiter with small cache and memory responder models.
`timescale 1ns/1ps
module tb_cache_port_arbiter;
  import mips_cache_pkg::*;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk, rst;
  logic          p0_req, p0_wr, p0_done, p0_err;
  logic [AW-1:0] p0_addr;
  logic [DW-1:0] p0_wdata, p0_rdata;
  logic          p1_req, p1_wr, p1_done, p1_err;
  logic [AW-1:0] p1_addr;
  logic [DW-1:0] p1_wdata, p1_rdata;
  logic          c_en, c_wr, c_hit;
  logic [AW-1:0] c_addr;
  logic [DW-1:0] c_wdata, c_rdata;
  logic          fill_en;
  logic [AW-1:0] fill_addr;
  logic [DW-1:0] fill_data;
  logic          mem_req, mem_we, mem_ack;
  logic [AW-1:0] mem_addr;
  logic [DW-1:0] mem_wdata, mem_rdata;
  state_t        state;

  int checks = 0;
  int errors = 0;

  // cache/memory model configuration
  logic          cfg_hit;
  logic [DW-1:0] cfg_crd, cfg_mrd;
  int            cfg_wait;
  int            mwait;

  // monitor
  int            fill_cnt, d0_cnt, d1_cnt;
  logic          mreq_seen, mwe_seen, cwr_seen;
  logic [AW-1:0] fill_a, ma_seen;
  logic [DW-1:0] fill_d, mwd_seen;

  cache_port_arbiter #(
    .AW(AW), .DW(DW)
`ifdef CACHE_ARB_TIMEOUT_EN
    , .TIMEOUT_CYCLES(8)
`endif
  ) dut (
    .clk(clk), .rst(rst),
    .p0_req(p0_req), .p0_wr(p0_wr), .p0_addr(p0_addr), .p0_wdata(p0_wdata),
    .p0_done(p0_done), .p0_rdata(p0_rdata), .p0_err(p0_err),
    .p1_req(p1_req), .p1_wr(p1_wr), .p1_addr(p1_addr), .p1_wdata(p1_wdata),
    .p1_done(p1_done), .p1_rdata(p1_rdata), .p1_err(p1_err),
    .c_en(c_en), .c_wr(c_wr), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_hit(c_hit), .c_rdata(c_rdata),
    .fill_en(fill_en), .fill_addr(fill_addr), .fill_data(fill_data),
    .mem_req(mem_req), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_ack(mem_ack), .mem_rdata(mem_rdata),
    .state(state)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // cache: registered hit/data the cycle after c_en
  always @(posedge clk) begin
    c_hit   <= c_en & cfg_hit;
    c_rdata <= c_en ? cfg_crd : '0;
  end

  // memory: ack after cfg_wait cycles of observed mem_req
  always @(posedge clk) begin
    if (!mem_req || mem_ack) begin
      mem_ack <= 1'b0;
      mwait   <= 0;
    end else if (mwait >= cfg_wait) begin
      mem_ack   <= 1'b1;
      mem_rdata <= cfg_mrd;
    end else begin
      mwait <= mwait + 1;
    end
  end

  always @(negedge clk) begin
    if (fill_en) begin fill_cnt++; fill_a = fill_addr; fill_d = fill_data; end
    if (mem_req) begin mreq_seen = 1'b1; mwe_seen = mem_we; ma_seen = mem_addr; mwd_seen = mem_wdata; end
    if (c_en && c_wr) cwr_seen = 1'b1;
    if (p0_done) d0_cnt++;
    if (p1_done) d1_cnt++;
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_mon();
    fill_cnt = 0; mreq_seen = 1'b0; mwe_seen = 1'b0; cwr_seen = 1'b0;
    fill_a = '0; fill_d = '0; ma_seen = '0; mwd_seen = '0;
  endtask

  // Drive one request on port p; lat counts req-high cycle as cycle 1.
  task automatic do_txn(input int p, input logic wr, input logic [AW-1:0] a,
                        input logic [DW-1:0] wd, input int drop_after,
                        output int lat, output logic [DW-1:0] rd, output logic er);
    int cyc;
    bit got;
    @(negedge clk);
    clear_mon();
    if (p == 0) begin p0_req = 1; p0_wr = wr; p0_addr = a; p0_wdata = wd; end
    else        begin p1_req = 1; p1_wr = wr; p1_addr = a; p1_wdata = wd; end
    cyc = 0; got = 0; rd = '0; er = 1'b0;
    while (!got && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (cyc == drop_after) begin p0_req = 0; p1_req = 0; end
      if (p == 0 && p0_done) begin got = 1; rd = p0_rdata; er = p0_err; end
      if (p == 1 && p1_done) begin got = 1; rd = p1_rdata; er = p1_err; end
    end
    p0_req = 0; p1_req = 0;
    if (!got) check("done_timeout", 64'd0, 64'd1);
    lat = cyc + 1;
  endtask

  // Both ports request together; record order and cycle of each done.
  task automatic tie_txn(input logic [DW-1:0] d, output int first, output int second,
                         output int cyc2);
    int cyc, n;
    @(negedge clk);
    cfg_hit = 1; cfg_crd = d;
    p0_req = 1; p0_wr = 0; p0_addr = 32'h10;
    p1_req = 1; p1_wr = 0; p1_addr = 32'h20;
    cyc = 0; n = 0; first = -1; second = -1; cyc2 = 0;
    while (n < 2 && cyc < 100) begin
      @(negedge clk);
      cyc++;
      if (p0_done) begin if (n == 0) first = 0; else begin second = 0; cyc2 = cyc; end n++; p0_req = 0; end
      if (p1_done) begin if (n == 0) first = 1; else begin second = 1; cyc2 = cyc; end n++; p1_req = 0; end
    end
    p0_req = 0; p1_req = 0;
    if (n < 2) check("tie_timeout", 64'd0, 64'd1);
  endtask

  int lat, f, s, c2, d0_before;
  logic [DW-1:0] rd;
  logic er;
  bit seen;

  initial begin
    rst = 1; p0_req = 0; p0_wr = 0; p0_addr = '0; p0_wdata = '0;
    p1_req = 0; p1_wr = 0; p1_addr = '0; p1_wdata = '0;
    cfg_hit = 0; cfg_crd = '0; cfg_mrd = '0; cfg_wait = 0;
    mem_ack = 0; mem_rdata = '0; mwait = 0; c_hit = 0; c_rdata = '0;
    d0_cnt = 0; d1_cnt = 0;
    clear_mon();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_state", 64'(state), 64'(IDLE));
    check("rst_outs", {58'd0, c_en, mem_req, fill_en, p0_done, p1_done, mem_we}, 64'd0);
    rst = 0;

    // tie from reset: p0 first, p1 granted at next IDLE
    tie_txn(32'h77, f, s, c2);
    check("tie1_first", 64'(f), 64'd0);
    check("tie1_second", 64'(s), 64'd1);
    check("tie1_p1_cycle", 64'(c2), 64'd7);
    tie_txn(32'h78, f, s, c2);
    check("tie2_first", 64'(f), 64'd0);
    check("tie2_second", 64'(s), 64'd1);

    // read hit
    cfg_hit = 1; cfg_crd = 32'h1234;
    do_txn(0, 0, 32'h100, 0, 0, lat, rd, er);
    check("hit_lat", 64'(lat), 64'd4);
    check("hit_rdata", 64'(rd), 64'h1234);
    check("hit_no_mem", 64'(mreq_seen), 64'd0);
    check("hit_err", 64'(er), 64'd0);

    // read miss with refill; memory waits 4 cycles (3 extra in the model)
    cfg_hit = 0; cfg_wait = 3; cfg_mrd = 32'hCAFE;
    do_txn(1, 0, 32'h200, 0, 0, lat, rd, er);
    check("miss_lat", 64'(lat), 64'd10);
    check("miss_rdata", 64'(rd), 64'hCAFE);
    check("miss_fill_cnt", 64'(fill_cnt), 64'd1);
    check("miss_fill_addr", 64'(fill_a), 64'h200);
    check("miss_fill_data", 64'(fill_d), 64'hCAFE);
    check("miss_mem_we", 64'(mwe_seen), 64'd0);

    // write-through, no allocate
    cfg_hit = 1; cfg_wait = 0;
    do_txn(1, 1, 32'h40, 32'h55, 0, lat, rd, er);
    check("wr_lat", 64'(lat), 64'd6);
    check("wr_c_wr", 64'(cwr_seen), 64'd1);
    check("wr_mem_we", 64'(mwe_seen), 64'd1);
    check("wr_mem_addr", 64'(ma_seen), 64'h40);
    check("wr_mem_wdata", 64'(mwd_seen), 64'h55);
    check("wr_no_fill", 64'(fill_cnt), 64'd0);

    // requester drops req early: still completes
    cfg_hit = 1; cfg_crd = 32'h9A9A;
    do_txn(0, 0, 32'h104, 0, 1, lat, rd, er);
    check("drop_lat", 64'(lat), 64'd4);
    check("drop_rdata", 64'(rd), 64'h9A9A);

    // reset while waiting in MEM
    cfg_hit = 0; cfg_wait = 10000;
    @(negedge clk);
    d0_before = d0_cnt;
    p0_req = 1; p0_wr = 0; p0_addr = 32'h300;
    seen = 0;
    for (int i = 0; i < 20 && !seen; i++) begin
      @(negedge clk);
      if (mem_req) seen = 1;
    end
    check("rst_mem_req_seen", 64'(seen), 64'd1);
    #2 rst = 1;
    #1;
    check("rst_async_mem_req", 64'(mem_req), 64'd0);
    check("rst_async_state", 64'(state), 64'(IDLE));
    p0_req = 0;
    @(negedge clk);
    rst = 0;
    repeat (3) @(negedge clk);
    check("rst_no_done", 64'(d0_cnt - d0_before), 64'd0);
    cfg_hit = 1; cfg_crd = 32'hBEEF; cfg_wait = 0;
    do_txn(0, 0, 32'h300, 0, 0, lat, rd, er);
    check("post_rst_lat", 64'(lat), 64'd4);
    check("post_rst_rdata", 64'(rd), 64'hBEEF);

`ifdef CACHE_ARB_TIMEOUT_EN
    cfg_hit = 0; cfg_wait = 100000; cfg_mrd = 32'h1111;
    do_txn(0, 0, 32'h500, 0, 0, lat, rd, er);
    check("to_lat", 64'(lat), 64'd12);
    check("to_err", 64'(er), 64'd1);
    check("to_rdata", 64'(rd), 64'd0);
    check("to_no_fill", 64'(fill_cnt), 64'd0);
    repeat (2) @(negedge clk);
    check("to_mem_req_low", 64'(mem_req), 64'd0);
    cfg_wait = 0;
`endif

    repeat (2) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
